// File: rtl/lru_state_array.sv
// Per-set storage for the 21-bit eight-way LRU state word. A sweep after reset
// or flush loads the canonical order into every set; reads are registered.
module lru_state_array #(
    parameter int s_index = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               ready,
    input  logic               rd_valid,
    input  logic [s_index-1:0] rd_index,
    output logic [20:0]        state_out,
    output logic [2:0]         lru_way,
    output logic               state_valid,
    input  logic               upd_valid,
    input  logic [s_index-1:0] upd_index,
    input  logic [20:0]        upd_state
);

    localparam int                 NSETS      = 2 ** s_index;
    localparam logic [20:0]        INIT_VALUE = 21'h1ac688;
    localparam logic [s_index-1:0] LAST_SET   = {s_index{1'b1}};
    localparam logic [s_index-1:0] PTR_ONE    = {{(s_index-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [s_index-1:0] init_ptr_q, init_ptr_d;
    logic               ready_q, ready_d;
    logic               state_valid_q, state_valid_d;
    logic [20:0]        state_out_q, state_out_d;
    logic [20:0]        array_q [NSETS];

    logic               we_s;
    logic [s_index-1:0] waddr_s;
    logic [20:0]        wdata_s;

    // Next-state, array write port and registered read data.
    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        ready_d       = ready_q;
        state_valid_d = 1'b0;
        state_out_d   = state_out_q;
        we_s          = 1'b0;
        waddr_s       = init_ptr_q;
        wdata_s       = INIT_VALUE;
        case (state_q)
            ST_INIT: begin
                if (flush) begin
                    init_ptr_d = '0;
                end else begin
                    we_s       = 1'b1;
                    init_ptr_d = init_ptr_q + PTR_ONE;
                    if (init_ptr_q == LAST_SET) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        ready_d = 1'b0;
                    end
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    // Requests presented alongside flush are dropped.
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                    ready_d    = 1'b0;
                end else begin
                    if (ready_q && upd_valid) begin
                        we_s    = 1'b1;
                        waddr_s = upd_index;
                        wdata_s = upd_state;
                    end else begin
                        we_s    = 1'b0;
                    end
                    if (ready_q && rd_valid) begin
                        state_valid_d = 1'b1;
                        if (upd_valid && (upd_index == rd_index)) begin
                            state_out_d = upd_state;
                        end else begin
                            state_out_d = array_q[rd_index];
                        end
                    end else begin
                        state_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_ptr_q    <= '0;
            ready_q       <= 1'b0;
            state_valid_q <= 1'b0;
            state_out_q   <= 21'h0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            ready_q       <= ready_d;
            state_valid_q <= state_valid_d;
            state_out_q   <= state_out_d;
        end
    end

    // Set storage; contents survive reset and are rewritten by the sweep.
    always_ff @(posedge clk) begin
        if (!rst && we_s) begin
            array_q[waddr_s] <= wdata_s;
        end
    end

    assign ready       = ready_q;
    assign state_valid = state_valid_q;
    assign state_out   = state_out_q;
    assign lru_way     = state_out_q[2:0];

endmodule

// File: tb/tb_lru_state_array.sv
// Scoreboard bench for lru_state_array: stimulus queues expected read data,
// a negedge monitor pops and compares whenever state_valid is presented.
module tb_lru_state_array;

    localparam logic [20:0] INIT_V = 21'h1ac688;

    logic        clk = 1'b0;
    logic        rst, flush, ready, rd_valid, state_valid, upd_valid;
    logic [2:0]  rd_index, upd_index, lru_way;
    logic [20:0] state_out, upd_state;

    logic [20:0] exp_q[$];
    bit          ready_chk = 1'b0;
    logic        exp_ready = 1'b0;
    bit          rst_chk   = 1'b0;
    bit          final_chk = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    lru_state_array #(.s_index(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ready(ready),
        .rd_valid(rd_valid), .rd_index(rd_index), .state_out(state_out),
        .lru_way(lru_way), .state_valid(state_valid),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_state(upd_state)
    );

    always #5 clk = ~clk;

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (state_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got state_out=%h, required no state_valid", state_out);
                end else begin
                    e = exp_q.pop_front();
                    if (state_out !== e) begin
                        n_err++;
                        $display("FAIL state_out: got %h, required %h", state_out, e);
                    end
                    n_cmp++;
                    if (lru_way !== e[2:0]) begin
                        n_err++;
                        $display("FAIL lru_way: got %0d, required %0d", lru_way, e[2:0]);
                    end
                end
            end
            if (ready_chk) begin
                n_cmp++;
                if (ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL ready: got %b, required %b at %0t", ready, exp_ready, $time);
                end
            end
            if (rst_chk) begin
                n_cmp++;
                if (state_out !== 21'h0 || state_valid !== 1'b0 || lru_way !== 3'd0) begin
                    n_err++;
                    $display("FAIL reset_state: got state_out=%h valid=%b lru=%0d, required 0/0/0",
                             state_out, state_valid, lru_way);
                end
            end
            if (final_chk) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_reads: got %0d outstanding, required 0", exp_q.size());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [2:0] idx, input logic [20:0] e);
        rd_valid = 1'b1;
        rd_index = idx;
        exp_q.push_back(e);
        step();
        rd_valid = 1'b0;
    endtask

    task automatic update(input logic [2:0] idx, input logic [20:0] v);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_state = v;
        step();
        upd_valid = 1'b0;
    endtask

    // Count 8 sweep edges, expecting ready only after the last one.
    task automatic sweep();
        for (int i = 1; i <= 8; i++) begin
            step();
            rst_chk   = 1'b0;
            exp_ready = (i == 8);
        end
    endtask

    // Stimulus.
    initial begin
        rst = 1'b1; flush = 1'b0; rd_valid = 1'b0; upd_valid = 1'b0;
        rd_index = 3'd0; upd_index = 3'd0; upd_state = 21'h0;
        step();
        step();
        rst_chk   = 1'b1;
        ready_chk = 1'b1;
        exp_ready = 1'b0;
        rst       = 1'b0;
        sweep();

        for (int i = 0; i < 8; i++) read(3'(i), INIT_V);

        update(3'd5, 21'h0fac68);
        read(3'd5, 21'h0fac68);
        read(3'd4, INIT_V);
        step();

        // Same-cycle update and read: matching index forwards, other index does not.
        upd_valid = 1'b1; upd_index = 3'd2; upd_state = 21'h123456;
        read(3'd2, 21'h123456);
        upd_valid = 1'b1; upd_index = 3'd2; upd_state = 21'h123456;
        read(3'd3, INIT_V);
        upd_valid = 1'b0;
        read(3'd2, 21'h123456);

        update(3'd1, 21'h0aaaaa);
        update(3'd7, 21'h155555);
        read(3'd1, 21'h0aaaaa);
        read(3'd7, 21'h155555);

        // Flush with a dropped update and read in the same cycle.
        flush = 1'b1;
        upd_valid = 1'b1; upd_index = 3'd3; upd_state = 21'h1fffff;
        rd_valid = 1'b1;  rd_index = 3'd1;
        step();
        exp_ready = 1'b0;
        flush = 1'b0; upd_valid = 1'b0; rd_valid = 1'b0;
        sweep();
        for (int i = 0; i < 8; i++) read(3'(i), INIT_V);

        // Requests held throughout a sweep must be ignored.
        flush = 1'b1;
        step();
        exp_ready = 1'b0;
        flush = 1'b0;
        rd_valid = 1'b1; rd_index = 3'd0;
        upd_valid = 1'b1; upd_index = 3'd0; upd_state = 21'h000001;
        sweep();
        rd_valid = 1'b0; upd_valid = 1'b0;
        read(3'd0, INIT_V);
        step();

        // Reset coinciding with an accepted read.
        update(3'd6, 21'h0c0c0c);
        rd_valid = 1'b1; rd_index = 3'd6; rst = 1'b1;
        step();
        rd_valid = 1'b0; rst = 1'b0;
        exp_ready = 1'b0;
        rst_chk   = 1'b1;
        sweep();
        read(3'd6, INIT_V);
        step();

        final_chk = 1'b1;
        step();
        final_chk = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
